conv2d_seq_engine: RTL and testbench

- Sequential, parametrised 2-D convolution engine; next generation of the flat-bus combinational conv top.
- Accepts a start pulse and flat tensor/weight/bias buses, and captures them into internal registers.
- Computes every output with a single time-multiplexed signed MAC, and streams results out over a valid/ready handshake.
- Adds zero padding, stride, multi-channel output, optional ReLU and saturation to DATA_WIDTH.

---
 rtl/conv2d_seq_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_conv2d_seq_engine.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_seq_engine.sv
// Sequential 2-D convolution engine: captures flat tensor/weight/bias buses, then computes
// each output with one time-multiplexed signed MAC and streams results over valid/ready.
module conv2d_seq_engine #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ACC_WIDTH    = 64,
    parameter int unsigned IN_CHANNELS  = 2,
    parameter int unsigned IN_HEIGHT    = 4,
    parameter int unsigned IN_WIDTH     = 4,
    parameter int unsigned OUT_CHANNELS = 1,
    parameter int unsigned KERNEL_SIZE  = 2,
    parameter int unsigned STRIDE       = 2,
    parameter int unsigned PADDING      = 0,
    parameter int unsigned RELU_EN      = 0,
    localparam int unsigned OUT_HEIGHT  = (IN_HEIGHT + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1,
    localparam int unsigned OUT_WIDTH   = (IN_WIDTH + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1,
    localparam int unsigned N_OUT       = OUT_CHANNELS * OUT_HEIGHT * OUT_WIDTH,
    localparam int unsigned IDX_WIDTH   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic [IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]  input_tensor_flat,
    input  logic [OUT_CHANNELS*IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights_flat,
    input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                    bias_flat,
    output logic                                                  busy,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [DATA_WIDTH-1:0]                                 out_data,
    output logic [IDX_WIDTH-1:0]                                  out_index,
    output logic                                                  done
);

    localparam int unsigned N_IN = IN_CHANNELS * IN_HEIGHT * IN_WIDTH;
    localparam int unsigned N_W  = OUT_CHANNELS * IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned IN_AW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned W_AW  = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int unsigned B_AW  = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
    localparam int unsigned CW    = 16;

    localparam logic [CW-1:0] C_LAST   = CW'(IN_CHANNELS - 1);
    localparam logic [CW-1:0] K_LAST   = CW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] O_LAST   = CW'(OUT_CHANNELS - 1);
    localparam logic [CW-1:0] OY_LAST  = CW'(OUT_HEIGHT - 1);
    localparam logic [CW-1:0] OX_LAST  = CW'(OUT_WIDTH - 1);
    localparam logic [CW-1:0] STRIDE_C = CW'(STRIDE);
    localparam logic [CW-1:0] PAD_C    = CW'(PADDING);
    localparam logic [CW-1:0] IH_C     = CW'(IN_HEIGHT);
    localparam logic [CW-1:0] IW_C     = CW'(IN_WIDTH);
    localparam logic [CW-1:0] IC_C     = CW'(IN_CHANNELS);
    localparam logic [CW-1:0] K_C      = CW'(KERNEL_SIZE);
    localparam logic [CW-1:0] OH_C     = CW'(OUT_HEIGHT);
    localparam logic [CW-1:0] OW_C     = CW'(OUT_WIDTH);
    localparam logic [CW-1:0] IH_END   = CW'(IN_HEIGHT + PADDING);
    localparam logic [CW-1:0] IW_END   = CW'(IN_WIDTH + PADDING);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StCapture, StInit, StMac, StOut, StFin} state_e;

    state_e r_state;
    state_e w_state_next;

    logic signed [DATA_WIDTH-1:0] r_in [N_IN];
    logic signed [DATA_WIDTH-1:0] r_w  [N_W];
    logic signed [DATA_WIDTH-1:0] r_b  [OUT_CHANNELS];

    logic [CW-1:0] r_o, r_oy, r_ox, r_c, r_ky, r_kx;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0]       r_out_data;
    logic [IDX_WIDTH-1:0]        r_out_index;

    logic [CW-1:0]                 w_iy_p, w_ix_p;
    logic                          w_in_range;
    logic [IN_AW-1:0]              w_in_idx;
    logic [W_AW-1:0]               w_w_idx;
    logic [B_AW-1:0]               w_b_idx;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]   w_term, w_acc_sum;
    logic [DATA_WIDTH-1:0]         w_res;
    logic                          w_mac_last, w_out_last;

    // Coordinates are kept in the padded frame so the bounds test stays unsigned.
    assign w_iy_p     = r_oy * STRIDE_C + r_ky;
    assign w_ix_p     = r_ox * STRIDE_C + r_kx;
    assign w_in_range = (w_iy_p >= PAD_C) && (w_iy_p < IH_END) &&
                        (w_ix_p >= PAD_C) && (w_ix_p < IW_END);
    assign w_in_idx   = IN_AW'((r_c * IH_C + (w_iy_p - PAD_C)) * IW_C + (w_ix_p - PAD_C));
    assign w_w_idx    = W_AW'(((r_o * IC_C + r_c) * K_C + r_ky) * K_C + r_kx);
    assign w_b_idx    = B_AW'(r_o);
    assign w_prod     = r_in[w_in_idx] * r_w[w_w_idx];
    assign w_term     = w_in_range ? ACC_WIDTH'(w_prod) : '0;
    assign w_acc_sum  = r_acc + w_term;
    assign w_mac_last = (r_c == C_LAST) && (r_ky == K_LAST) && (r_kx == K_LAST);
    assign w_out_last = (r_o == O_LAST) && (r_oy == OY_LAST) && (r_ox == OX_LAST);

    always_comb begin
        w_res = w_acc_sum[DATA_WIDTH-1:0];
        if ((RELU_EN != 0) && (w_acc_sum < 0)) begin
            w_res = '0;
        end else if (w_acc_sum > SAT_MAX) begin
            w_res = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else if (w_acc_sum < SAT_MIN) begin
            w_res = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        out_valid    = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            StIdle: begin
                busy = 1'b0;
                if (start) w_state_next = StCapture;
            end
            StCapture: w_state_next = StInit;
            StInit:    w_state_next = StMac;
            StMac: begin
                if (w_mac_last) w_state_next = StOut;
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = w_out_last ? StFin : StInit;
            end
            StFin: begin
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Operand buffers are only written during capture, so they need no reset.
    always_ff @(posedge clk) begin
        if (r_state == StCapture) begin
            for (int i = 0; i < int'(N_IN); i++) begin
                r_in[i] <= input_tensor_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int i = 0; i < int'(N_W); i++) begin
                r_w[i] <= weights_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int i = 0; i < int'(OUT_CHANNELS); i++) begin
                r_b[i] <= bias_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_o         <= '0;
            r_oy        <= '0;
            r_ox        <= '0;
            r_c         <= '0;
            r_ky        <= '0;
            r_kx        <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_index <= '0;
        end else begin
            case (r_state)
                StCapture: begin
                    r_o  <= '0;
                    r_oy <= '0;
                    r_ox <= '0;
                end
                StInit: begin
                    r_acc <= ACC_WIDTH'(r_b[w_b_idx]);
                    r_c   <= '0;
                    r_ky  <= '0;
                    r_kx  <= '0;
                end
                StMac: begin
                    r_acc <= w_acc_sum;
                    if (r_kx == K_LAST) begin
                        r_kx <= '0;
                        if (r_ky == K_LAST) begin
                            r_ky <= '0;
                            r_c  <= r_c + CNT_ONE;
                        end else begin
                            r_ky <= r_ky + CNT_ONE;
                        end
                    end else begin
                        r_kx <= r_kx + CNT_ONE;
                    end
                    if (w_mac_last) begin
                        r_out_data  <= w_res;
                        r_out_index <= IDX_WIDTH'((r_o * OH_C + r_oy) * OW_C + r_ox);
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        if (r_ox == OX_LAST) begin
                            r_ox <= '0;
                            if (r_oy == OY_LAST) begin
                                r_oy <= '0;
                                r_o  <= r_o + CNT_ONE;
                            end else begin
                                r_oy <= r_oy + CNT_ONE;
                            end
                        end else begin
                            r_ox <= r_ox + CNT_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_index = r_out_index;

endmodule

// File: tb/tb_conv2d_seq_engine.sv
// Bench for conv2d_seq_engine: a default-parameter instance and a padded, 8-bit, ReLU,
// two-output-channel instance, both checked against a plain-arithmetic convolution model.
module tb_conv2d_seq_engine;

    localparam int A_N_IN = 32, A_N_W = 8, A_N_OUT = 4;
    localparam int B_N_IN = 9, B_N_W = 18, B_N_OUT = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, ready_a, busy_a, valid_a, done_a;
    logic [A_N_IN*32-1:0] in_bus_a;
    logic [A_N_W*32-1:0]  w_bus_a;
    logic [31:0]          b_bus_a;
    logic [31:0]          data_a;
    logic [1:0]           idx_a;

    logic start_b, ready_b, busy_b, valid_b, done_b;
    logic [B_N_IN*8-1:0]  in_bus_b;
    logic [B_N_W*8-1:0]   w_bus_b;
    logic [15:0]          b_bus_b;
    logic [7:0]           data_b;
    logic [4:0]           idx_b;

    int checks = 0;
    int errors = 0;

    longint a_in[64], a_w[64], a_b[4], a_got[32];
    longint b_in[64], b_w[64], b_b[4], b_got[32];

    conv2d_seq_engine u_dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .input_tensor_flat(in_bus_a), .weights_flat(w_bus_a), .bias_flat(b_bus_a),
        .busy(busy_a), .out_valid(valid_a), .out_ready(ready_a),
        .out_data(data_a), .out_index(idx_a), .done(done_a)
    );

    conv2d_seq_engine #(
        .DATA_WIDTH(8), .ACC_WIDTH(24), .IN_CHANNELS(1), .IN_HEIGHT(3), .IN_WIDTH(3),
        .OUT_CHANNELS(2), .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1), .RELU_EN(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .input_tensor_flat(in_bus_b), .weights_flat(w_bus_b), .bias_flat(b_bus_b),
        .busy(busy_b), .out_valid(valid_b), .out_ready(ready_b),
        .out_data(data_b), .out_index(idx_b), .done(done_b)
    );

    // Direct convolution over the padded input, then accumulator wrap, ReLU, saturation.
    function automatic longint ref_out(input int dw, aw, ic, ih, iw, k, s, p, relu, n,
                                       input longint inp[64], input longint wt[64],
                                       input longint bs[4]);
        int oh, ow, o, oy, ox, iy, ix;
        longint acc, hi, lo;
        oh = (ih + 2 * p - k) / s + 1;
        ow = (iw + 2 * p - k) / s + 1;
        o  = n / (oh * ow);
        oy = (n / ow) % oh;
        ox = n % ow;
        acc = bs[o];
        for (int c = 0; c < ic; c++)
            for (int ky = 0; ky < k; ky++)
                for (int kx = 0; kx < k; kx++) begin
                    iy = oy * s + ky - p;
                    ix = ox * s + kx - p;
                    if (iy >= 0 && iy < ih && ix >= 0 && ix < iw)
                        acc += inp[(c * ih + iy) * iw + ix] * wt[((o * ic + c) * k + ky) * k + kx];
                end
        if (aw < 64) acc = (acc <<< (64 - aw)) >>> (64 - aw);
        if (relu != 0 && acc < 0) acc = 0;
        hi = (longint'(1) <<< (dw - 1)) - 1;
        lo = -hi - 1;
        if (acc > hi) acc = hi;
        else if (acc < lo) acc = lo;
        return acc;
    endfunction

    function automatic longint ref_a(input int n);
        return ref_out(32, 64, 2, 4, 4, 2, 2, 0, 0, n, a_in, a_w, a_b);
    endfunction

    function automatic longint ref_b(input int n);
        return ref_out(8, 24, 1, 3, 3, 3, 1, 1, 1, n, b_in, b_w, b_b);
    endfunction

    function automatic longint rnd32(input bit full);
        logic [31:0] t;
        t = $urandom;
        if (!full) return longint'($urandom_range(0, 15)) - 8;
        return longint'($signed(t));
    endfunction

    function automatic longint rnd8();
        logic [7:0] t;
        t = 8'($urandom);
        return longint'($signed(t));
    endfunction

    task automatic pack_a();
        for (int i = 0; i < A_N_IN; i++) in_bus_a[i*32 +: 32] = a_in[i][31:0];
        for (int i = 0; i < A_N_W; i++) w_bus_a[i*32 +: 32] = a_w[i][31:0];
        b_bus_a = a_b[0][31:0];
    endtask

    task automatic pack_b();
        for (int i = 0; i < B_N_IN; i++) in_bus_b[i*8 +: 8] = b_in[i][7:0];
        for (int i = 0; i < B_N_W; i++) w_bus_b[i*8 +: 8] = b_w[i][7:0];
        b_bus_b = {b_b[1][7:0], b_b[0][7:0]};
    endtask

    task automatic scramble();
        for (int i = 0; i < A_N_IN; i++) in_bus_a[i*32 +: 32] = $urandom;
        for (int i = 0; i < A_N_W; i++) w_bus_a[i*32 +: 32] = $urandom;
        b_bus_a = $urandom;
        for (int i = 0; i < B_N_IN; i++) in_bus_b[i*8 +: 8] = 8'($urandom);
        for (int i = 0; i < B_N_W; i++) w_bus_b[i*8 +: 8] = 8'($urandom);
        b_bus_b = 16'($urandom);
    endtask

    // mode 0: ready tied high (cycle count checked); 1: 3-cycle stall on output 1; 2: random.
    task automatic run_job_a(input int mode, input bit poke);
        int n = 0, stall = 0, done_cyc = 0;
        bit seen_done = 0;
        longint exp;
        pack_a();
        @(negedge clk);
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 3000 && !seen_done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start_a = 1'b0;
                checks++;
                if (busy_a !== 1'b1) begin
                    errors++; $display("FAIL a_busy_capture got %b want 1", busy_a);
                end
            end
            if (cyc == 2) scramble();
            if (poke) start_a = (cyc == 15);
            if (done_a === 1'b1) begin
                seen_done = 1;
                done_cyc  = cyc;
            end else if (valid_a === 1'b1) begin
                checks++;
                if (n >= A_N_OUT) begin
                    errors++; $display("FAIL a_extra_output got index %0d after %0d outputs", idx_a, n);
                end else begin
                    exp = ref_a(n);
                    if (idx_a !== 2'(n) || longint'($signed(data_a)) !== exp) begin
                        errors++;
                        $display("FAIL a_output got idx %0d data %0d want idx %0d data %0d",
                                 idx_a, $signed(data_a), n, exp);
                    end
                end
                if (mode == 1) ready_a = !(n == 1 && stall < 3);
                else if (mode == 2) ready_a = 1'($urandom_range(0, 1));
                else ready_a = 1'b1;
                if (n == 1 && !ready_a) stall++;
                if (ready_a) begin
                    if (n < 32) a_got[n] = longint'($signed(data_a));
                    n++;
                end
            end else begin
                ready_a = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        start_a = 1'b0;
        checks++;
        if (!seen_done || n != A_N_OUT) begin
            errors++; $display("FAIL a_job_end got done %0d outputs %0d want done 1 outputs %0d",
                               seen_done, n, A_N_OUT);
        end
        if (mode == 0) begin
            checks++;
            if (done_cyc != 2 + A_N_OUT * (2 + 2 * 2 * 2)) begin
                errors++; $display("FAIL a_latency got %0d want %0d", done_cyc,
                                   2 + A_N_OUT * (2 + 2 * 2 * 2));
            end
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL a_after_done got done %b busy %b want 0 0", done_a, busy_a);
        end
        if (poke) begin
            int busy_seen = 0;
            repeat (8) begin
                @(negedge clk);
                if (busy_a !== 1'b0) busy_seen++;
            end
            checks++;
            if (busy_seen != 0) begin
                errors++; $display("FAIL a_start_while_busy got %0d busy cycles want 0", busy_seen);
            end
        end
        ready_a = 1'b1;
    endtask

    task automatic run_job_b(input int mode);
        int n = 0, done_cyc = 0;
        bit seen_done = 0;
        longint exp;
        pack_b();
        @(negedge clk);
        start_b = 1'b1;
        for (int cyc = 1; cyc <= 5000 && !seen_done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start_b = 1'b0;
            if (cyc == 2) scramble();
            if (done_b === 1'b1) begin
                seen_done = 1;
                done_cyc  = cyc;
            end else if (valid_b === 1'b1) begin
                checks++;
                if (n >= B_N_OUT) begin
                    errors++; $display("FAIL b_extra_output got index %0d after %0d outputs", idx_b, n);
                end else begin
                    exp = ref_b(n);
                    if (idx_b !== 5'(n) || longint'($signed(data_b)) !== exp) begin
                        errors++;
                        $display("FAIL b_output got idx %0d data %0d want idx %0d data %0d",
                                 idx_b, $signed(data_b), n, exp);
                    end
                end
                ready_b = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (ready_b) begin
                    if (n < 32) b_got[n] = longint'($signed(data_b));
                    n++;
                end
            end else begin
                ready_b = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        checks++;
        if (!seen_done || n != B_N_OUT) begin
            errors++; $display("FAIL b_job_end got done %0d outputs %0d want done 1 outputs %0d",
                               seen_done, n, B_N_OUT);
        end
        if (mode == 0) begin
            checks++;
            if (done_cyc != 2 + B_N_OUT * (2 + 9)) begin
                errors++; $display("FAIL b_latency got %0d want %0d", done_cyc, 2 + B_N_OUT * 11);
            end
        end
        ready_b = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, valid_a, done_a, busy_b, valid_b, done_b} !== 6'b0 ||
            data_a !== 32'd0 || idx_a !== 2'd0 || data_b !== 8'd0 || idx_b !== 5'd0) begin
            errors++;
            $display("FAIL reset_state got a %b%b%b %h %0d b %b%b%b %h %0d want all zero",
                     busy_a, valid_a, done_a, data_a, idx_a, busy_b, valid_b, done_b, data_b, idx_b);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ones_a();
        for (int i = 0; i < 64; i++) begin a_in[i] = 1; a_w[i] = 1; end
        a_b[0] = 0;
        run_job_a(0, 0);
        for (int i = 0; i < A_N_OUT; i++) begin
            checks++;
            if (a_got[i] !== 64'sd8) begin
                errors++; $display("FAIL a_ones[%0d] got %0d want 8", i, a_got[i]);
            end
        end
    endtask

    task automatic test_negative_a();
        for (int i = 0; i < 64; i++) begin a_in[i] = 5; a_w[i] = -1; end
        a_b[0] = 0;
        run_job_a(0, 0);
        checks++;
        if (a_got[0] !== -64'sd40) begin
            errors++; $display("FAIL a_negative got %0d want -40", a_got[0]);
        end
    endtask

    task automatic test_random_a();
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 64; i++) begin a_in[i] = rnd32(t[0]); a_w[i] = rnd32(t[0]); end
            a_b[0] = rnd32(t[0]);
            run_job_a(t % 3, 0);
        end
    endtask

    task automatic test_backpressure_a();
        for (int i = 0; i < 64; i++) begin a_in[i] = rnd32(0); a_w[i] = rnd32(0); end
        a_b[0] = rnd32(0);
        run_job_a(1, 0);
    endtask

    task automatic test_start_while_busy_a();
        for (int i = 0; i < 64; i++) begin a_in[i] = rnd32(1); a_w[i] = rnd32(0); end
        a_b[0] = rnd32(1);
        run_job_a(0, 1);
    endtask

    task automatic test_reset_mid_a();
        int stray = 0;
        for (int i = 0; i < 64; i++) begin a_in[i] = rnd32(0); a_w[i] = rnd32(0); end
        a_b[0] = 7;
        run_job_a(0, 0);
        for (int i = 0; i < 64; i++) begin a_in[i] = rnd32(1); a_w[i] = rnd32(1); end
        a_b[0] = rnd32(1);
        pack_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0 || data_a !== 32'd0 || idx_a !== 2'd0) begin
            errors++; $display("FAIL a_reset_mid got busy %b valid %b data %h idx %0d want 0 0 0 0",
                               busy_a, valid_a, data_a, idx_a);
        end
        repeat (50) begin
            @(negedge clk);
            if (valid_a !== 1'b0 || done_a !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL a_abandoned got %0d stray cycles want 0", stray);
        end
        run_job_a(0, 0);
    endtask

    task automatic test_padding_b();
        int tab[9];
        tab = '{12, 21, 16, 27, 45, 33, 24, 39, 28};
        for (int i = 0; i < 64; i++) begin b_in[i] = i + 1; b_w[i] = 1; end
        b_b[0] = 0;
        b_b[1] = -20;
        run_job_b(0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (b_got[i] !== longint'(tab[i])) begin
                errors++; $display("FAIL b_padding[%0d] got %0d want %0d", i, b_got[i], tab[i]);
            end
        end
        checks++;
        if (b_got[9] !== 64'sd0 || b_got[13] !== 64'sd25) begin
            errors++; $display("FAIL b_bias_relu got %0d %0d want 0 25", b_got[9], b_got[13]);
        end
    endtask

    task automatic test_sat_b();
        for (int i = 0; i < 64; i++) begin b_in[i] = 127; b_w[i] = 127; end
        b_b[0] = 0;
        b_b[1] = 0;
        run_job_b(0);
        checks++;
        if (b_got[4] !== 64'sd127) begin
            errors++; $display("FAIL b_sat_pos got %0d want 127", b_got[4]);
        end
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 64; i++) begin b_in[i] = rnd8(); b_w[i] = rnd8(); end
            b_b[0] = rnd8();
            b_b[1] = rnd8();
            run_job_b(2);
        end
    endtask

    task automatic test_relu_b();
        for (int i = 0; i < 64; i++) begin b_in[i] = 5; b_w[i] = -1; end
        b_b[0] = 0;
        b_b[1] = 0;
        run_job_b(0);
        checks++;
        if (b_got[0] !== 64'sd0 || b_got[4] !== 64'sd0) begin
            errors++; $display("FAIL b_relu got %0d %0d want 0 0", b_got[0], b_got[4]);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        in_bus_a = '0;
        w_bus_a = '0;
        b_bus_a = '0;
        in_bus_b = '0;
        w_bus_b = '0;
        b_bus_b = '0;
        test_reset();
        test_ones_a();
        test_negative_a();
        test_random_a();
        test_backpressure_a();
        test_start_while_busy_a();
        test_reset_mid_a();
        test_padding_b();
        test_sat_b();
        test_relu_b();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
